// File: rtl/reg_wb_pkg.sv
// -----------------------------------------------------------------------------
// reg_wb_pkg
//   Shared definitions for the write-back controller slice:
//   data width, RISC-V load funct3 encodings, the x0 register index,
//   the load-queue entry layout and the load-data extension helper.
// -----------------------------------------------------------------------------
package reg_wb_pkg;

    localparam int XLEN = 32;

    // Architectural zero register; writes to it are suppressed.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Load size/sign encodings (instruction funct3 field).
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // One outstanding load: where the data goes and how to extend it.
    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
    } ldq_entry_t;

    // Sign/zero-extend right-aligned raw load data according to funct3.
    // Unknown encodings fall back to full-width (LW) behaviour.
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      funct3,
                                                    input logic [XLEN-1:0] raw);
        logic [XLEN-1:0] res;
        case (funct3)
            F3_LB:   res = {{(XLEN-8){raw[7]}},   raw[7:0]};
            F3_LH:   res = {{(XLEN-16){raw[15]}}, raw[15:0]};
            F3_LBU:  res = {{(XLEN-8){1'b0}},     raw[7:0]};
            F3_LHU:  res = {{(XLEN-16){1'b0}},    raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/reg_wb_ldq.sv
// -----------------------------------------------------------------------------
// reg_wb_ldq
//   Synchronous FIFO of outstanding loads ({rd, funct3}), DEPTH entries.
//   Responses come back in issue order, so the head always describes the
//   next response to arrive.
//
// Ports
//   clk_i        in   clock, all state on posedge
//   rst_i        in   asynchronous active-high reset (empties the queue)
//   push_i       in   enqueue push_entry_i (ignored when full)
//   push_entry_i in   entry to enqueue
//   pop_i        in   dequeue head (ignored when empty)
//   full_o       out  queue holds DEPTH entries
//   empty_o      out  queue holds no entries
//   head_o       out  oldest entry (meaningless while empty)
// -----------------------------------------------------------------------------
module reg_wb_ldq
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  ldq_entry_t push_entry_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output ldq_entry_t head_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the indices coincide.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    ldq_entry_t  mem_q [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Full is derived from registered pointers only, so a pop in the same
    // cycle does not free a slot for a push until the next cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry_i;
        end
    end

endmodule

// File: rtl/reg_wb_ctrl.sv
// -----------------------------------------------------------------------------
// reg_wb_ctrl
//   Write-back controller; the only initiator of the register bank write
//   port. Each cycle it selects at most one write source, in priority order
//   load response > skid entry > fresh ALU beat, and registers it onto
//   reg_we/rd/rd_val (one cycle latency; the bank updates one edge later).
//   Outstanding loads are tracked in an in-order queue plus a per-register
//   busy vector, which also feeds the decode-stage hazard flags.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
//   ready are both high. Ready never depends on the same-cycle valid. The
//   load response channel has no ready: a response is consumed the cycle it
//   is presented.
//
// Ports
//   clk, rst                        clock / asynchronous active-high reset
//   alu_valid/alu_rd/alu_data       ALU result offer
//   alu_ready                       ALU result accept
//   ld_issue_valid/_rd/_funct3      load issue to memory
//   ld_issue_ready                  load issue accept
//   ld_resp_valid/ld_resp_data      in-order raw load data
//   rs1, rs2 / rs1_busy, rs2_busy   decode-stage source hazard query
//   reg_we, rd, rd_val              register bank write port
//   resp_err                        sticky: response seen with no load queued
// -----------------------------------------------------------------------------
module reg_wb_ctrl
    import reg_wb_pkg::*;
#(
    parameter int LDQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_issue_valid,
    input  logic [4:0]      ld_issue_rd,
    input  logic [2:0]      ld_issue_funct3,
    output logic            ld_issue_ready,
    input  logic            ld_resp_valid,
    input  logic [XLEN-1:0] ld_resp_data,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            reg_we,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_val,
    output logic            resp_err
);

    // Per-register "write pending, not yet in the bank" flags.
    logic [31:0]     busy_q, busy_d;

    // One-entry skid for an ALU beat that lost arbitration to a load response.
    logic            skid_v_q, skid_v_d;
    logic [4:0]      skid_rd_q, skid_rd_d;
    logic [XLEN-1:0] skid_data_q, skid_data_d;

    // Registered write port.
    logic            reg_we_q, reg_we_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rd_val_q, rd_val_d;

    logic            resp_err_q, resp_err_d;

    // Load queue interface.
    logic            ldq_push;
    logic            ldq_pop;
    logic            ldq_full;
    logic            ldq_empty;
    ldq_entry_t      ldq_head;
    ldq_entry_t      ldq_push_entry;

    logic            alu_fire;
    logic            iss_fire;

    reg_wb_ldq #(
        .DEPTH (LDQ_DEPTH)
    ) u_ldq (
        .clk_i        (clk),
        .rst_i        (rst),
        .push_i       (ldq_push),
        .push_entry_i (ldq_push_entry),
        .pop_i        (ldq_pop),
        .full_o       (ldq_full),
        .empty_o      (ldq_empty),
        .head_o       (ldq_head)
    );

    // A pending load to the same rd blocks the ALU beat, which keeps the
    // ALU write from overtaking it (WAW). Both terms are registered.
    assign alu_ready = !skid_v_q && !busy_q[alu_rd];

    // A new load must not race an older pending write to the same rd,
    // whether that write is a queued load or a parked ALU beat.
    assign ld_issue_ready = !ldq_full && !busy_q[ld_issue_rd] &&
                            !(skid_v_q && (skid_rd_q == ld_issue_rd));

    assign alu_fire       = alu_valid && alu_ready;
    assign iss_fire       = ld_issue_valid && ld_issue_ready;
    assign ldq_push       = iss_fire;
    assign ldq_push_entry = '{rd: ld_issue_rd, funct3: ld_issue_funct3};

    // A source is hazardous while its write is queued, parked in the skid,
    // or sitting on the write port waiting for the bank to absorb it.
    assign rs1_busy = (rs1 != REG_X0) &&
                      (busy_q[rs1] || (reg_we_q && (rd_q == rs1)) ||
                       (skid_v_q && (skid_rd_q == rs1)));
    assign rs2_busy = (rs2 != REG_X0) &&
                      (busy_q[rs2] || (reg_we_q && (rd_q == rs2)) ||
                       (skid_v_q && (skid_rd_q == rs2)));

    always_comb begin
        busy_d      = busy_q;
        skid_v_d    = skid_v_q;
        skid_rd_d   = skid_rd_q;
        skid_data_d = skid_data_q;
        reg_we_d    = 1'b0;
        rd_d        = rd_q;
        rd_val_d    = rd_val_q;
        resp_err_d  = resp_err_q;
        ldq_pop     = 1'b0;

        if (ld_resp_valid) begin
            if (ldq_empty) begin
                // Nothing to match the response against: drop it.
                resp_err_d = 1'b1;
            end else begin
                ldq_pop  = 1'b1;
                reg_we_d = (ldq_head.rd != REG_X0);
                rd_d     = ldq_head.rd;
                rd_val_d = load_extend(ldq_head.funct3, ld_resp_data);
                // The hazard flag hands over to the reg_we/rd term above.
                busy_d[ldq_head.rd] = 1'b0;
            end
            // The response owns the write slot; park an accepted ALU beat.
            if (alu_fire) begin
                skid_v_d    = 1'b1;
                skid_rd_d   = alu_rd;
                skid_data_d = alu_data;
            end
        end else if (skid_v_q) begin
            // alu_ready is low while the skid is full, so no new beat here.
            skid_v_d = 1'b0;
            reg_we_d = (skid_rd_q != REG_X0);
            rd_d     = skid_rd_q;
            rd_val_d = skid_data_q;
        end else if (alu_fire) begin
            reg_we_d = (alu_rd != REG_X0);
            rd_d     = alu_rd;
            rd_val_d = alu_data;
        end

        // x0 is never tracked; its loads still occupy a queue slot.
        if (iss_fire && (ld_issue_rd != REG_X0)) begin
            busy_d[ld_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= '0;
            skid_v_q    <= 1'b0;
            skid_rd_q   <= '0;
            skid_data_q <= '0;
            reg_we_q    <= 1'b0;
            rd_q        <= '0;
            rd_val_q    <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            skid_v_q    <= skid_v_d;
            skid_rd_q   <= skid_rd_d;
            skid_data_q <= skid_data_d;
            reg_we_q    <= reg_we_d;
            rd_q        <= rd_d;
            rd_val_q    <= rd_val_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign reg_we   = reg_we_q;
    assign rd       = rd_q;
    assign rd_val   = rd_val_q;
    assign resp_err = resp_err_q;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_wb_ctrl
//   Directed bench for reg_wb_ctrl. Each table row is one clock cycle:
//   inputs are driven after the falling edge and all outputs are sampled
//   2 time units later, before the next rising edge. Combinational outputs
//   reflect this row's inputs; reg_we/rd/rd_val/resp_err reflect the action
//   taken on the previous row's edge.
// -----------------------------------------------------------------------------
module tb_reg_wb_ctrl;
    import reg_wb_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            ld_issue_valid;
    logic [4:0]      ld_issue_rd;
    logic [2:0]      ld_issue_funct3;
    logic            ld_issue_ready;
    logic            ld_resp_valid;
    logic [XLEN-1:0] ld_resp_data;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            reg_we;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_val;
    logic            resp_err;

    reg_wb_ctrl #(
        .LDQ_DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .alu_ready       (alu_ready),
        .ld_issue_valid  (ld_issue_valid),
        .ld_issue_rd     (ld_issue_rd),
        .ld_issue_funct3 (ld_issue_funct3),
        .ld_issue_ready  (ld_issue_ready),
        .ld_resp_valid   (ld_resp_valid),
        .ld_resp_data    (ld_resp_data),
        .rs1             (rs1),
        .rs2             (rs2),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .reg_we          (reg_we),
        .rd              (rd),
        .rd_val          (rd_val),
        .resp_err        (resp_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- vector record ----------------
    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        iss_v;
        logic [4:0]  iss_rd;
        logic [2:0]  iss_f3;
        logic        resp_v;
        logic [31:0] resp_data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_ar;
        logic        e_ir;
        logic        e_b1;
        logic        e_b2;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_val;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(
        input logic [31:0] av,  input logic [31:0] ard, input logic [31:0] adat,
        input logic [31:0] iv,  input logic [31:0] ird, input logic [31:0] if3,
        input logic [31:0] rv,  input logic [31:0] rdat,
        input logic [31:0] r1,  input logic [31:0] r2,
        input logic [31:0] ear, input logic [31:0] eir,
        input logic [31:0] eb1, input logic [31:0] eb2,
        input logic [31:0] ewe, input logic [31:0] erd, input logic [31:0] evl,
        input logic [31:0] eer);
        vec_t v;
        v.alu_v     = av[0];
        v.alu_rd    = ard[4:0];
        v.alu_data  = adat;
        v.iss_v     = iv[0];
        v.iss_rd    = ird[4:0];
        v.iss_f3    = if3[2:0];
        v.resp_v    = rv[0];
        v.resp_data = rdat;
        v.rs1       = r1[4:0];
        v.rs2       = r2[4:0];
        v.e_ar      = ear[0];
        v.e_ir      = eir[0];
        v.e_b1      = eb1[0];
        v.e_b2      = eb2[0];
        v.e_we      = ewe[0];
        v.e_rd      = erd[4:0];
        v.e_val     = evl;
        v.e_err     = eer[0];
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input vec_t v);
        alu_valid       = v.alu_v;
        alu_rd          = v.alu_rd;
        alu_data        = v.alu_data;
        ld_issue_valid  = v.iss_v;
        ld_issue_rd     = v.iss_rd;
        ld_issue_funct3 = v.iss_f3;
        ld_resp_valid   = v.resp_v;
        ld_resp_data    = v.resp_data;
        rs1             = v.rs1;
        rs2             = v.rs2;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk_field(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s %s: got 0x%0h expected 0x%0h", name, field, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input vec_t v);
        n_vec++;
        chk_field(name, "alu_ready",      32'(alu_ready),      32'(v.e_ar));
        chk_field(name, "ld_issue_ready", 32'(ld_issue_ready), 32'(v.e_ir));
        chk_field(name, "rs1_busy",       32'(rs1_busy),       32'(v.e_b1));
        chk_field(name, "rs2_busy",       32'(rs2_busy),       32'(v.e_b2));
        chk_field(name, "reg_we",         32'(reg_we),         32'(v.e_we));
        chk_field(name, "resp_err",       32'(resp_err),       32'(v.e_err));
        if (v.e_we) begin
            chk_field(name, "rd",     32'(rd), 32'(v.e_rd));
            chk_field(name, "rd_val", rd_val,  v.e_val);
        end
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        chk_field(name, "reg_we",   32'(reg_we),   32'd0);
        chk_field(name, "rd",       32'(rd),       32'd0);
        chk_field(name, "rd_val",   rd_val,        32'd0);
        chk_field(name, "resp_err", 32'(resp_err), 32'd0);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        @(negedge clk);
        drive(v);
        #2;
        check_vec(name, v);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        vec_t idle;
        //           av ard adat        iv ird f3  rv rdat          r1 r2  ar ir b1 b2  we rd val          err
        // ALU write, one-cycle latency
        tbl.push_back(mk(1, 5, 'h1234,    0, 0, 0,  0, 0,            5, 0,  1, 1, 0, 0,  0, 0, 0,           0));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  0, 0,            5, 0,  1, 1, 1, 0,  1, 5, 'h1234,      0));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  0, 0,            5, 0,  1, 1, 0, 0,  0, 0, 0,           0));
        // LB / LBU / LH extension, rs busy window
        tbl.push_back(mk(0, 0, 0,         1, 7, 0,  0, 0,            7, 0,  1, 1, 0, 0,  0, 0, 0,           0));
        tbl.push_back(mk(0, 7, 0,         0, 0, 0,  0, 0,            7, 0,  0, 1, 1, 0,  0, 0, 0,           0));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  1, 'h80,         7, 0,  1, 1, 1, 0,  0, 0, 0,           0));
        tbl.push_back(mk(0, 0, 0,         1, 7, 4,  0, 0,            7, 0,  1, 1, 1, 0,  1, 7, 'hFFFFFF80,  0));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  1, 'h80,         7, 0,  1, 1, 1, 0,  0, 0, 0,           0));
        tbl.push_back(mk(0, 0, 0,         1, 9, 1,  0, 0,            7, 9,  1, 1, 1, 0,  1, 7, 'h80,        0));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  1, 'h8001,       7, 9,  1, 1, 0, 1,  0, 0, 0,           0));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  0, 0,            0, 9,  1, 1, 0, 1,  1, 9, 'hFFFF8001,  0));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  0, 0,            0, 9,  1, 1, 0, 0,  0, 0, 0,           0));
        // Response and ALU in the same cycle: ALU parks in the skid
        tbl.push_back(mk(0, 0, 0,         1, 10, 2, 0, 0,            0, 0,  1, 1, 0, 0,  0, 0, 0,           0));
        tbl.push_back(mk(1, 11, 'h55,     0, 0, 0,  1, 'hDEADBEEF,  11, 10, 1, 1, 0, 1,  0, 0, 0,           0));
        tbl.push_back(mk(1, 12, 'h66,     0, 11, 0, 0, 0,           11, 10, 0, 0, 1, 1,  1, 10, 'hDEADBEEF, 0));
        tbl.push_back(mk(1, 12, 'h66,     0, 0, 0,  0, 0,           11, 0,  1, 1, 1, 0,  1, 11, 'h55,       0));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  0, 0,           12, 0,  1, 1, 1, 0,  1, 12, 'h66,       0));
        // ALU to a register with a pending load waits for the load write
        tbl.push_back(mk(0, 0, 0,         1, 3, 2,  0, 0,            3, 0,  1, 1, 0, 0,  0, 0, 0,           0));
        tbl.push_back(mk(1, 3, 'h77,      0, 0, 0,  0, 0,            3, 0,  0, 1, 1, 0,  0, 0, 0,           0));
        tbl.push_back(mk(1, 3, 'h77,      0, 0, 0,  1, 'h33,         3, 0,  0, 1, 1, 0,  0, 0, 0,           0));
        tbl.push_back(mk(1, 3, 'h77,      0, 0, 0,  0, 0,            3, 0,  1, 1, 1, 0,  1, 3, 'h33,        0));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  0, 0,            3, 0,  1, 1, 1, 0,  1, 3, 'h77,        0));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  0, 0,            3, 0,  1, 1, 0, 0,  0, 0, 0,           0));
        // Fill the queue, full blocks issue even while popping, x0 load
        tbl.push_back(mk(0, 0, 0,         1, 1, 0,  0, 0,            0, 0,  1, 1, 0, 0,  0, 0, 0,           0));
        tbl.push_back(mk(0, 0, 0,         1, 2, 1,  0, 0,            0, 0,  1, 1, 0, 0,  0, 0, 0,           0));
        tbl.push_back(mk(0, 0, 0,         1, 0, 2,  0, 0,            0, 0,  1, 1, 0, 0,  0, 0, 0,           0));
        tbl.push_back(mk(0, 0, 0,         1, 4, 5,  0, 0,            0, 0,  1, 1, 0, 0,  0, 0, 0,           0));
        tbl.push_back(mk(0, 0, 0,         1, 6, 2,  0, 0,            1, 4,  1, 0, 1, 1,  0, 0, 0,           0));
        tbl.push_back(mk(0, 0, 0,         1, 6, 2,  1, 'hFF,         1, 4,  1, 0, 1, 1,  0, 0, 0,           0));
        tbl.push_back(mk(0, 0, 0,         1, 6, 2,  1, 'h1234,       1, 2,  1, 1, 1, 1,  1, 1, 'hFFFFFFFF,  0));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  1, 'hABCD,       6, 0,  1, 1, 1, 0,  1, 2, 'h1234,      0));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  1, 'hFFFF8001,   0, 4,  1, 1, 0, 1,  0, 0, 0,           0));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  1, 'h11223344,   6, 4,  1, 1, 1, 1,  1, 4, 'h8001,      0));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  0, 0,            6, 0,  1, 1, 1, 0,  1, 6, 'h11223344,  0));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  0, 0,            6, 0,  1, 1, 0, 0,  0, 0, 0,           0));
        // Response with an empty queue sets the sticky error
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  1, 'h99,         0, 0,  1, 1, 0, 0,  0, 0, 0,           0));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  0, 0,            0, 0,  1, 1, 0, 0,  0, 0, 0,           1));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  0, 0,            0, 0,  1, 1, 0, 0,  0, 0, 0,           1));
        // Unknown funct3 behaves as LW
        tbl.push_back(mk(0, 0, 0,         1, 5, 7,  0, 0,            0, 0,  1, 1, 0, 0,  0, 0, 0,           1));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  1, 'hF0000080,   5, 0,  1, 1, 1, 0,  0, 0, 0,           1));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  0, 0,            0, 0,  1, 1, 0, 0,  1, 5, 'hF0000080,  1));
        tbl.push_back(mk(0, 0, 0,         0, 0, 0,  0, 0,            0, 0,  1, 1, 0, 0,  0, 0, 0,           1));

        // ---- reset ----
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(idle);
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset_regs");
        check_vec("reset_comb", idle);
        rst = 1'b0;

        // ---- table ----
        foreach (tbl[i]) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // ---- reset mid-flight: pending load and skid entry are discarded ----
        run_vec("mr_issue", mk(0, 0, 0,    1, 8, 2,   0, 0,    0, 0,   1, 1, 0, 0,  0, 0, 0, 1));
        run_vec("mr_fill",  mk(1, 20, 'hAA, 1, 13, 2, 1, 'h5,  20, 0,  1, 1, 0, 0,  0, 0, 0, 1));
        run_vec("mr_state", mk(0, 0, 0,    0, 0, 0,   0, 0,    20, 13, 0, 1, 1, 1,  1, 8, 'h5, 1));
        rst = 1'b1;
        #1;
        check_zero("mr_rst_regs");
        check_vec("mr_rst_comb", mk(0, 0, 0, 0, 0, 0, 0, 0, 20, 13, 1, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        run_vec("mr_post0", mk(0, 0, 0, 0, 0, 0, 0, 0,    20, 13, 1, 1, 0, 0,  0, 0, 0, 0));
        run_vec("mr_post1", mk(0, 0, 0, 0, 0, 0, 1, 'h7,  20, 13, 1, 1, 0, 0,  0, 0, 0, 0));
        run_vec("mr_post2", mk(0, 0, 0, 0, 0, 0, 0, 0,    0, 0,   1, 1, 0, 0,  0, 0, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
